// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arbiter (with internal wallace_tree_multiplier)
// Purpose  : Shares one combinational Wallace-tree multiplier among NUM_REQ
//            requesters. Round-robin grant into an operand stage (S1), whose
//            registers feed the multiplier; the product is captured in S2 and
//            returned on a single response bus tagged with the requester ID.
//            Sustains one multiply per cycle.
// Ports    : clk          rising-edge clock
//            reset        asynchronous active-high reset
//            req_valid    per-requester operand valid
//            req_ready    per-requester grant (one-hot or zero, combinational)
//            req_in1/2    packed operands, slice i = [i*W +: W]
//            rsp_valid    product valid
//            rsp_ready    consumer accepts product
//            rsp_id       requester that issued the product
//            rsp_product  full-width unsigned product
//            busy         S1 or S2 occupied
// Revision : 1.0  initial release
// ============================================================================

// Unsigned multiplier: partial products reduced by levels of 3:2 carry-save
// compressors until two rows remain, then one carry-propagate add.
module wallace_tree_multiplier #(
    parameter int A_W = 16,
    parameter int B_W = 16
) (
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic [A_W+B_W-1:0] product
);
    localparam int P_W = A_W + B_W;

    // Row count after a given number of reduction levels.
    function automatic int rows_after(input int levels);
        int r;
        r = B_W;
        for (int k = 0; k < levels; k++) begin
            if (r > 2) r = 2 * (r / 3) + (r % 3);
        end
        return r;
    endfunction

    function automatic int num_levels();
        int r;
        int n;
        r = B_W;
        n = 0;
        for (int k = 0; k < B_W; k++) begin
            if (r > 2) begin
                r = 2 * (r / 3) + (r % 3);
                n++;
            end
        end
        return n;
    endfunction

    localparam int LEVELS = num_levels();
    // One spare row so the final adder always has two operands, even for B_W=1.
    localparam int ROWS   = B_W + 1;

    logic [P_W-1:0] tree [LEVELS+1][ROWS];

    for (genvar r = 0; r < ROWS; r++) begin : g_pp
        if (r < B_W) begin : g_pp_row
            assign tree[0][r] = b[r] ? (P_W'(a) << r) : '0;
        end else begin : g_pp_zero
            assign tree[0][r] = '0;
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int R_IN   = rows_after(l);
        localparam int GROUPS = R_IN / 3;
        localparam int R_OUT  = rows_after(l + 1);
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            if (r < 2 * GROUPS) begin : g_csa
                localparam int G = r / 2;
                if (r % 2 == 0) begin : g_sum
                    assign tree[l+1][r] = tree[l][3*G] ^ tree[l][3*G+1] ^ tree[l][3*G+2];
                end else begin : g_carry
                    // Carry out of the top bit cannot matter: the exact product fits P_W.
                    assign tree[l+1][r] = ((tree[l][3*G]   & tree[l][3*G+1]) |
                                           (tree[l][3*G]   & tree[l][3*G+2]) |
                                           (tree[l][3*G+1] & tree[l][3*G+2])) << 1;
                end
            end else if (r < R_OUT) begin : g_pass
                // Rows left over from an incomplete group of three move down unchanged.
                assign tree[l+1][r] = tree[l][r + GROUPS];
            end else begin : g_zero
                assign tree[l+1][r] = '0;
            end
        end
    end

    assign product = tree[LEVELS][0] + tree[LEVELS][1];
endmodule

module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IN1_W   = 16,
    parameter int IN2_W   = 16,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*IN1_W-1:0] req_in1,
    input  logic [NUM_REQ*IN2_W-1:0] req_in2,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [IN1_W+IN2_W-1:0]   rsp_product,
    output logic                     busy
);
    localparam int PROD_W = IN1_W + IN2_W;

    logic                op_valid;
    logic [IN1_W-1:0]    op_a;
    logic [IN2_W-1:0]    op_b;
    logic [ID_W-1:0]     op_id;
    logic [ID_W-1:0]     rr_ptr;

    logic                s2_adv;
    logic                s1_free;
    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W:0]       cand;
    logic                xfer;
    logic [ID_W-1:0]     next_ptr;
    logic [PROD_W-1:0]   mult_out;

    logic [IN1_W-1:0]    in1_arr [NUM_REQ];
    logic [IN2_W-1:0]    in2_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign in1_arr[g] = req_in1[g*IN1_W +: IN1_W];
        assign in2_arr[g] = req_in2[g*IN2_W +: IN2_W];
    end

    assign s2_adv  = !rsp_valid || rsp_ready;
    assign s1_free = !op_valid || s2_adv;

    // Rotating-priority search: walk from the far end toward rr_ptr so the
    // last hit written is the first valid requester at or above rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
            if (req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Reset gates the grant directly so no requester sees a handshake while
    // the pipeline is being cleared.
    assign xfer = grant_found && s1_free && !reset;

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[grant_idx] = 1'b1;
    end

    assign next_ptr = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    wallace_tree_multiplier #(
        .A_W (IN1_W),
        .B_W (IN2_W)
    ) u_mult (
        .a       (op_a),
        .b       (op_b),
        .product (mult_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_valid    <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            op_id       <= '0;
            rr_ptr      <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
        end else begin
            // S1 may refill on the same edge it drains into S2.
            if (s1_free) begin
                op_valid <= xfer;
                if (xfer) begin
                    op_a   <= in1_arr[grant_idx];
                    op_b   <= in2_arr[grant_idx];
                    op_id  <= grant_idx;
                    rr_ptr <= next_ptr;
                end
            end
            if (s2_adv) begin
                rsp_valid <= op_valid;
                if (op_valid) begin
                    rsp_product <= mult_out;
                    rsp_id      <= op_id;
                end
            end
        end
    end

    assign busy = op_valid || rsp_valid;
endmodule
`default_nettype wire
